// File: rtl/bj_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// bj_redirect_ctrl
//   Sequences one branch/jump at a time after decode: resolves direction and
//   target, writes the link register for BL/JIRL, then issues a front-end
//   redirect. Only one op is in flight; in_ready is high only in IDLE.
//
// Parameters
//   XLEN      datapath width
//   REG_AW    register index width
//   LINK_REG  destination index used by BL
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      issue handshake
//   bj_op_type               decoded op (`BJ_* / `INVALID_OP_4B)
//   pc, rj_val, rd_val       instruction PC and compare/base operands
//   offs                     sign-extended, pre-shifted offset
//   rd_idx                   JIRL link destination index
//   flush_i                  abort the in-flight op
//   wb_valid/wb_ready        link write handshake, wb_idx/wb_data payload
//   redir_valid/redir_ready  redirect handshake, redir_pc payload
//   flush_o                  front-end flush (redirect handshake cycle)
//   err_o                    1-cycle pulse: invalid op or misaligned taken target
//
// Optional feature (macro BJ_PERF_CNT_EN)
//   Adds perf_bj_cnt (valid ops entering RESOLVE) and perf_taken_cnt
//   (completed redirect handshakes), 32 bits each, wrapping.
// ----------------------------------------------------------------------------

// Op encodings; normally provided by defs.sv, defaulted here if absent.
`ifndef BJ_BEQ
`define BJ_BEQ 4'h0
`endif
`ifndef BJ_BNE
`define BJ_BNE 4'h1
`endif
`ifndef BJ_BLT
`define BJ_BLT 4'h2
`endif
`ifndef BJ_BGE
`define BJ_BGE 4'h3
`endif
`ifndef BJ_BLTU
`define BJ_BLTU 4'h4
`endif
`ifndef BJ_BGEU
`define BJ_BGEU 4'h5
`endif
`ifndef BJ_B
`define BJ_B 4'h6
`endif
`ifndef BJ_BL
`define BJ_BL 4'h7
`endif
`ifndef BJ_JIRL
`define BJ_JIRL 4'h8
`endif
`ifndef INVALID_OP_4B
`define INVALID_OP_4B 4'hF
`endif

module bj_redirect_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LINK_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        bj_op_type,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rj_val,
    input  logic [XLEN-1:0]   rd_val,
    input  logic [XLEN-1:0]   offs,
    input  logic [REG_AW-1:0] rd_idx,
    input  logic              flush_i,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_idx,
    output logic [XLEN-1:0]   wb_data,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [XLEN-1:0]   redir_pc,
    output logic              flush_o,
    output logic              err_o
`ifdef BJ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bj_cnt,
    output logic [31:0]       perf_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESOLVE,
        S_LINK,
        S_REDIRECT
    } state_e;

    state_e state_q, state_d;

    // Latched issue operands
    logic [3:0]        op_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rj_q;
    logic [XLEN-1:0]   rd_q;
    logic [XLEN-1:0]   offs_q;
    logic [REG_AW-1:0] rd_idx_q;

    // Output payload registers
    logic [REG_AW-1:0] wb_idx_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [XLEN-1:0]   redir_pc_q;
    logic              err_q;

    // Resolve results (valid while in RESOLVE)
    logic              taken;
    logic [XLEN-1:0]   target;
    logic              link_op;
    logic [REG_AW-1:0] link_idx;
    logic              link_en;
    logic              misaligned;

    logic              accept;
    logic              in_is_bj;

    function automatic logic is_bj_op(input logic [3:0] op);
        logic r;
        case (op)
            `BJ_BEQ, `BJ_BNE, `BJ_BLT, `BJ_BGE, `BJ_BLTU, `BJ_BGEU,
            `BJ_B, `BJ_BL, `BJ_JIRL: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    assign in_is_bj = is_bj_op(bj_op_type);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Direction / target / link resolution from latched operands
    // ------------------------------------------------------------------
    always_comb begin
        taken    = 1'b0;
        link_op  = 1'b0;
        link_idx = '0;
        case (op_q)
            `BJ_BEQ:  taken = (rj_q == rd_q);
            `BJ_BNE:  taken = (rj_q != rd_q);
            `BJ_BLT:  taken = ($signed(rj_q) <  $signed(rd_q));
            `BJ_BGE:  taken = ($signed(rj_q) >= $signed(rd_q));
            `BJ_BLTU: taken = (rj_q <  rd_q);
            `BJ_BGEU: taken = (rj_q >= rd_q);
            `BJ_B:    taken = 1'b1;
            `BJ_BL: begin
                taken    = 1'b1;
                link_op  = 1'b1;
                link_idx = REG_AW'(LINK_REG);
            end
            `BJ_JIRL: begin
                taken    = 1'b1;
                link_op  = 1'b1;
                link_idx = rd_idx_q;
            end
            default:  taken = 1'b0;
        endcase
    end

    assign target     = ((op_q == `BJ_JIRL) ? rj_q : pc_q) + offs_q;
    assign misaligned = taken && (target[1:0] != 2'b00);
    // Writes to register 0 are discarded, so skip the LINK state entirely.
    assign link_en    = link_op && (link_idx != '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && in_is_bj) begin
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (misaligned) begin
                    state_d = S_IDLE;
                end else if (link_en) begin
                    state_d = S_LINK;
                end else if (taken) begin
                    state_d = S_REDIRECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LINK: begin
                if (wb_ready) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redir_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush in IDLE must not cancel a same-cycle accept.
        if (flush_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = (state_q == S_IDLE) && rst_n;
        wb_valid    = (state_q == S_LINK);
        redir_valid = (state_q == S_REDIRECT);
        flush_o     = redir_valid && redir_ready;
        wb_idx      = wb_idx_q;
        wb_data     = wb_data_q;
        redir_pc    = redir_pc_q;
        err_o       = err_q;
    end

    // ------------------------------------------------------------------
    // Operand latch and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= `INVALID_OP_4B;
            pc_q       <= '0;
            rj_q       <= '0;
            rd_q       <= '0;
            offs_q     <= '0;
            rd_idx_q   <= '0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            redir_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                op_q     <= bj_op_type;
                pc_q     <= pc;
                rj_q     <= rj_val;
                rd_q     <= rd_val;
                offs_q   <= offs;
                rd_idx_q <= rd_idx;
                if (!in_is_bj) begin
                    err_q <= 1'b1;
                end
            end
            // Payloads are only written when leaving RESOLVE, so they stay
            // stable for the whole LINK/REDIRECT handshake.
            if ((state_q == S_RESOLVE) && !flush_i) begin
                if (misaligned) begin
                    err_q <= 1'b1;
                end else begin
                    wb_idx_q   <= link_idx;
                    wb_data_q  <= pc_q + XLEN'(4);
                    redir_pc_q <= target;
                end
            end
        end
    end

`ifdef BJ_PERF_CNT_EN
    logic [31:0] perf_bj_q;
    logic [31:0] perf_taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bj_q    <= '0;
            perf_taken_q <= '0;
        end else begin
            if (accept && in_is_bj) begin
                perf_bj_q <= perf_bj_q + 32'd1;
            end
            if (flush_o) begin
                perf_taken_q <= perf_taken_q + 32'd1;
            end
        end
    end

    assign perf_bj_cnt    = perf_bj_q;
    assign perf_taken_cnt = perf_taken_q;
`endif

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bj_redirect_ctrl
//   Self-checking bench for bj_redirect_ctrl: directed vector table, hand
//   sequences for flush/reset corner cases, and randomized ops checked
//   against a behavioural model of the branch rules.
// ----------------------------------------------------------------------------
module tb_bj_redirect_ctrl;

    localparam logic [3:0] OP_BEQ  = 4'h0;
    localparam logic [3:0] OP_BNE  = 4'h1;
    localparam logic [3:0] OP_BLT  = 4'h2;
    localparam logic [3:0] OP_BGE  = 4'h3;
    localparam logic [3:0] OP_BLTU = 4'h4;
    localparam logic [3:0] OP_BGEU = 4'h5;
    localparam logic [3:0] OP_B    = 4'h6;
    localparam logic [3:0] OP_BL   = 4'h7;
    localparam logic [3:0] OP_JIRL = 4'h8;
    localparam logic [3:0] OP_INV  = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  bj_op_type;
    logic [31:0] pc;
    logic [31:0] rj_val;
    logic [31:0] rd_val;
    logic [31:0] offs;
    logic [4:0]  rd_idx;
    logic        flush_i;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    bj_redirect_ctrl #(
        .XLEN     (32),
        .REG_AW   (5),
        .LINK_REG (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bj_op_type  (bj_op_type),
        .pc          (pc),
        .rj_val      (rj_val),
        .rd_val      (rd_val),
        .offs        (offs),
        .rd_idx      (rd_idx),
        .flush_i     (flush_i),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .flush_o     (flush_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [31:0] offs;
        logic [4:0]  idx;
        int unsigned wst;     // cycles wb_ready held low
        int unsigned rst;     // cycles redir_ready held low
        logic        e_err;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic        e_wb;
        logic [4:0]  e_widx;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: branch rules evaluated directly on the operands.
    function automatic vec_t model(input vec_t v);
        vec_t  r;
        logic  valid_op;
        logic  t;
        logic [31:0] tgt;
        r        = v;
        valid_op = (v.op <= OP_JIRL);
        t        = 1'b0;
        case (v.op)
            OP_BEQ:  t = (v.rj == v.rd);
            OP_BNE:  t = (v.rj != v.rd);
            // signed compare via bias: flipping the sign bit maps signed order onto unsigned order
            OP_BLT:  t = ((v.rj ^ 32'h8000_0000) <  (v.rd ^ 32'h8000_0000));
            OP_BGE:  t = !((v.rj ^ 32'h8000_0000) < (v.rd ^ 32'h8000_0000));
            OP_BLTU: t = (v.rj < v.rd);
            OP_BGEU: t = !(v.rj < v.rd);
            OP_B, OP_BL, OP_JIRL: t = 1'b1;
            default: t = 1'b0;
        endcase
        tgt       = ((v.op == OP_JIRL) ? v.rj : v.pc) + v.offs;
        r.e_taken = t;
        r.e_tgt   = tgt;
        r.e_err   = !valid_op || (t && (tgt % 4 != 0));
        r.e_widx  = (v.op == OP_BL) ? 5'd1 : v.idx;
        r.e_wdata = v.pc + 32'd4;
        r.e_wb    = !r.e_err && ((v.op == OP_BL) || (v.op == OP_JIRL && v.idx != 5'd0));
        return r;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] p, input logic [31:0] rj,
                         input logic [31:0] rd, input logic [31:0] of, input logic [4:0] idx);
        in_valid   = 1'b1;
        bj_op_type = op;
        pc         = p;
        rj_val     = rj;
        rd_val     = rd;
        offs       = of;
        rd_idx     = idx;
        step();
        in_valid   = 1'b0;
    endtask

    // Issue one op and follow it through every state with cycle-exact checks.
    task automatic run_op(input vec_t v);
        check("in_ready_pre", in_ready, 1);
        issue(v.op, v.pc, v.rj, v.rd, v.offs, v.idx);
        if (v.op > OP_JIRL) begin
            check("inv_err", err_o, 1);
            check("inv_in_ready", in_ready, 1);
            check("inv_redir", redir_valid, 0);
            step();
            check("inv_err_clr", err_o, 0);
            return;
        end
        check("res_in_ready", in_ready, 0);
        check("res_err", err_o, 0);
        check("res_valids", {wb_valid, redir_valid}, 0);
        step();
        if (v.e_err) begin
            check("mis_err", err_o, 1);
            check("mis_in_ready", in_ready, 1);
            check("mis_valids", {wb_valid, redir_valid}, 0);
            step();
            check("mis_err_clr", err_o, 0);
            check("mis_valids2", {wb_valid, redir_valid}, 0);
            return;
        end
        if (v.e_wb) begin
            for (int i = 0; i < int'(v.wst); i++) begin
                check("wb_hold_valid", wb_valid, 1);
                check("wb_hold_idx", wb_idx, v.e_widx);
                check("wb_hold_data", wb_data, v.e_wdata);
                step();
            end
            check("wb_valid", wb_valid, 1);
            check("wb_idx", wb_idx, v.e_widx);
            check("wb_data", wb_data, v.e_wdata);
            check("wb_no_redir", redir_valid, 0);
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
        end else begin
            check("no_wb", wb_valid, 0);
        end
        if (v.e_taken) begin
            for (int i = 0; i < int'(v.rst); i++) begin
                check("redir_hold_valid", redir_valid, 1);
                check("redir_hold_pc", redir_pc, v.e_tgt);
                check("redir_hold_flush", flush_o, 0);
                step();
            end
            check("redir_valid", redir_valid, 1);
            check("redir_pc", redir_pc, v.e_tgt);
            check("redir_wb_off", wb_valid, 0);
            redir_ready = 1'b1;
            #1;
            check("flush_o_hs", flush_o, 1);
            step();
            redir_ready = 1'b0;
            check("post_redir_valid", redir_valid, 0);
            check("post_in_ready", in_ready, 1);
        end else begin
            check("nt_in_ready", in_ready, 1);
            check("nt_redir", redir_valid, 0);
        end
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        bj_op_type  = '0;
        pc          = '0;
        rj_val      = '0;
        rd_val      = '0;
        offs        = '0;
        rd_idx      = '0;
        flush_i     = 1'b0;
        wb_ready    = 1'b0;
        redir_ready = 1'b0;

        //           op       pc            rj            rd            offs          idx  wst rst err taken tgt        wb  widx wdata
        tbl[0]  = '{OP_BEQ,  32'h1000,     32'd5,        32'd5,        32'h40,       5'd0, 0, 0, 0, 1, 32'h1040,     0, 5'd0, 32'h1004};
        tbl[1]  = '{OP_BLT,  32'h100,      32'hFFFFFFFF, 32'd1,        32'h10,       5'd0, 0, 1, 0, 1, 32'h110,      0, 5'd0, 32'h104};
        tbl[2]  = '{OP_BLTU, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h10,       5'd0, 0, 0, 0, 0, 32'h110,      0, 5'd0, 32'h104};
        tbl[3]  = '{OP_BL,   32'h2000,     32'd0,        32'd0,        32'hFFFFFFF8, 5'd9, 2, 0, 0, 1, 32'h1FF8,     1, 5'd1, 32'h2004};
        tbl[4]  = '{OP_JIRL, 32'h800,      32'h3000,     32'd0,        32'd4,        5'd0, 0, 0, 0, 1, 32'h3004,     0, 5'd0, 32'h804};
        tbl[5]  = '{OP_JIRL, 32'h800,      32'h3002,     32'd0,        32'd4,        5'd3, 0, 0, 1, 1, 32'h3006,     0, 5'd3, 32'h804};
        tbl[6]  = '{OP_INV,  32'h900,      32'd0,        32'd0,        32'd0,        5'd0, 0, 0, 1, 0, 32'h900,      0, 5'd0, 32'h904};
        tbl[7]  = '{OP_BNE,  32'h400,      32'd1,        32'd2,        32'd8,        5'd0, 0, 3, 0, 1, 32'h408,      0, 5'd0, 32'h404};
        tbl[8]  = '{OP_BGEU, 32'h500,      32'h80000000, 32'h80000000, 32'hFFFFFF00, 5'd0, 0, 0, 0, 1, 32'h400,      0, 5'd0, 32'h504};
        tbl[9]  = '{OP_JIRL, 32'h600,      32'hFFFFFFF0, 32'd0,        32'h20,       5'd7, 1, 2, 0, 1, 32'h10,       1, 5'd7, 32'h604};
        tbl[10] = '{OP_B,    32'hFFFFFFFC, 32'd0,        32'd0,        32'd8,        5'd0, 0, 0, 0, 1, 32'h4,        0, 5'd0, 32'h0};
        tbl[11] = '{OP_BGE,  32'h700,      32'h7FFFFFFF, 32'h80000000, 32'd2,        5'd0, 0, 0, 1, 1, 32'h702,      0, 5'd0, 32'h704};

        // Reset values while reset is asserted
        #12;
        check("rst_valids", {wb_valid, redir_valid, flush_o, err_o}, 0);
        check("rst_wb_idx", wb_idx, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_redir_pc", redir_pc, 0);
        #6 rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i]);
        end

        // flush_i in REDIRECT without handshake drops the redirect
        issue(OP_B, 32'h500, 32'd0, 32'd0, 32'h20, 5'd0);
        step();
        check("fl_redir_valid", redir_valid, 1);
        flush_i = 1'b1;
        #1;
        check("fl_no_flush_o", flush_o, 0);
        step();
        flush_i = 1'b0;
        check("fl_redir_drop", redir_valid, 0);
        check("fl_in_ready", in_ready, 1);
        step();
        check("fl_stays_idle", redir_valid, 0);

        // flush_i in LINK with same-cycle wb handshake: write completes, no redirect
        issue(OP_BL, 32'h1000, 32'd0, 32'd0, 32'h100, 5'd0);
        step();
        check("fl_link_wb", wb_valid, 1);
        flush_i  = 1'b1;
        wb_ready = 1'b1;
        step();
        flush_i  = 1'b0;
        wb_ready = 1'b0;
        check("fl_link_valids", {wb_valid, redir_valid}, 0);
        check("fl_link_idle", in_ready, 1);

        // flush_i together with in_valid in IDLE: op still accepted
        flush_i = 1'b1;
        issue(OP_BEQ, 32'h2200, 32'd9, 32'd9, 32'h10, 5'd0);
        flush_i = 1'b0;
        check("fl_idle_accept", in_ready, 0);
        step();
        check("fl_idle_redir", redir_valid, 1);
        check("fl_idle_pc", redir_pc, 32'h2210);
        redir_ready = 1'b1;
        #1;
        check("fl_idle_flush_o", flush_o, 1);
        step();
        redir_ready = 1'b0;
        check("fl_idle_done", in_ready, 1);

        // Asynchronous reset in the middle of LINK
        issue(OP_BL, 32'h3000, 32'd0, 32'd0, 32'h40, 5'd0);
        step();
        check("rl_wb_valid", wb_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rl_valids", {wb_valid, redir_valid, flush_o, err_o}, 0);
        check("rl_wb_idx", wb_idx, 0);
        check("rl_wb_data", wb_data, 0);
        check("rl_redir_pc", redir_pc, 0);
        #1 rst_n = 1'b1;
        step();
        check("rl_in_ready", in_ready, 1);
        check("rl_post_valids", {wb_valid, redir_valid}, 0);

        // Randomized ops against the reference model
        for (int n = 0; n < 80; n++) begin
            rv.op   = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            rv.pc   = $urandom & 32'hFFFF_FFFC;
            rv.rj   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            case ($urandom_range(0, 3))
                0:       rv.rd = rv.rj;
                1:       rv.rd = rv.rj ^ 32'h8000_0000;
                default: rv.rd = $urandom;
            endcase
            rv.offs = ($urandom_range(0, 4) == 0) ? $urandom : (32'($signed(12'($urandom))) & 32'hFFFF_FFFC);
            rv.idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rv.wst  = $urandom_range(0, 3);
            rv.rst  = $urandom_range(0, 3);
            rv      = model(rv);
            run_op(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
